// File: rtl/dac_serial_receiver.sv
`default_nettype none
// ============================================================================
//  Module      : dac_serial_receiver
//  Description : Oversampling receiver for the three-wire DAC load interface
//                (serial clock, serial data, active-low chip select). Frames
//                are reassembled MSB first into a parallel word, validated by
//                bit count, and tallied in good-frame and error counters.
//  Revision    : 1.0 - initial release
// ============================================================================
module dac_serial_receiver #(
    parameter int DATA_WIDTH = 8,
    parameter int FCNT_WIDTH = 16
) (
    input  logic                  clk,
    input  logic                  rst_n,
    input  logic                  dac_clk,
    input  logic                  dac_din,
    input  logic                  dac_cs,
    output logic [DATA_WIDTH-1:0] data_out,
    output logic                  data_valid,
    output logic                  frame_err,
    output logic                  busy,
    output logic [FCNT_WIDTH-1:0] frame_count,
    output logic [7:0]            err_count
);

    // Bit counter must hold DATA_WIDTH+1, its saturation value.
    localparam int              CNT_W    = $clog2(DATA_WIDTH + 2);
    localparam logic [CNT_W-1:0] CNT_FULL = CNT_W'(DATA_WIDTH);
    localparam logic [CNT_W-1:0] CNT_MAX  = CNT_W'(DATA_WIDTH + 1);

    typedef enum logic [1:0] {
        IDLE = 2'd0,
        ARM  = 2'd1,
        RECV = 2'd2
    } state_t;

    // Per-pin pipeline: [0] = s1, [1] = s2, [2] = s3 (history).
    logic [2:0] clk_sync;
    logic [2:0] din_sync;
    logic [2:0] cs_sync;

    logic clk_rise;
    logic cs_fall;
    logic cs_rise;
    logic cs_low;
    logic din_s;

    state_t state;
    state_t state_next;
    logic   start_frame;
    logic   shift_en;
    logic   eval_frame;

    logic [DATA_WIDTH-1:0] shift_reg;
    logic [CNT_W-1:0]      bit_cnt;

    // Two-stage synchronizer plus one history stage for edge decode.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            clk_sync <= '0;
            din_sync <= '0;
            cs_sync  <= '0;
        end else begin
            clk_sync <= {clk_sync[1:0], dac_clk};
            din_sync <= {din_sync[1:0], dac_din};
            cs_sync  <= {cs_sync[1:0],  dac_cs};
        end
    end

    assign clk_rise = clk_sync[1] & ~clk_sync[2];
    assign cs_fall  = ~cs_sync[1] &  cs_sync[2];
    assign cs_rise  =  cs_sync[1] & ~cs_sync[2];
    assign cs_low   = ~cs_sync[1];
    assign din_s    = din_sync[1];

    // Frame state register.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state <= IDLE;
        end else begin
            state <= state_next;
        end
    end

    // Next-state and datapath strobes. A low cs seen in IDLE without a
    // falling edge means we joined a frame midway (e.g. after reset), so
    // that partial frame is skipped in ARM. cs rise takes priority over a
    // coincident clock rise, so that bit is never counted.
    always_comb begin
        state_next  = state;
        start_frame = 1'b0;
        shift_en    = 1'b0;
        eval_frame  = 1'b0;
        case (state)
            IDLE: begin
                if (cs_fall) begin
                    state_next  = RECV;
                    start_frame = 1'b1;
                end else if (cs_low) begin
                    state_next = ARM;
                end
            end
            ARM: begin
                if (cs_rise) begin
                    state_next = IDLE;
                end
            end
            RECV: begin
                if (cs_rise) begin
                    state_next = IDLE;
                    eval_frame = 1'b1;
                end else if (clk_rise && cs_low) begin
                    shift_en = 1'b1;
                end
            end
            default: begin
                state_next = IDLE;
            end
        endcase
    end

    // Shift register and bit counter; a clock rise coincident with the
    // cs fall is captured as the first bit of the fresh frame.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            shift_reg <= '0;
            bit_cnt   <= '0;
        end else if (start_frame) begin
            shift_reg <= {{(DATA_WIDTH-1){1'b0}}, din_s & clk_rise};
            bit_cnt   <= clk_rise ? CNT_W'(1) : '0;
        end else if (shift_en) begin
            shift_reg <= {shift_reg[DATA_WIDTH-2:0], din_s};
            if (bit_cnt != CNT_MAX) begin
                bit_cnt <= bit_cnt + CNT_W'(1);
            end
        end
    end

    // Frame evaluation: publish good words, count good and bad frames.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            data_out    <= '0;
            data_valid  <= 1'b0;
            frame_err   <= 1'b0;
            frame_count <= '0;
            err_count   <= '0;
        end else begin
            data_valid <= 1'b0;
            frame_err  <= 1'b0;
            if (eval_frame) begin
                if (bit_cnt == CNT_FULL) begin
                    data_out    <= shift_reg;
                    data_valid  <= 1'b1;
                    frame_count <= frame_count + FCNT_WIDTH'(1);
                end else begin
                    frame_err <= 1'b1;
                    if (err_count != 8'hFF) begin
                        err_count <= err_count + 8'd1;
                    end
                end
            end
        end
    end

    assign busy = (state == RECV);

endmodule
`default_nettype wire

// File: tb/tb_dac_serial_receiver.sv
`default_nettype none
`timescale 1ns/1ps
// ============================================================================
//  Module      : tb_dac_serial_receiver
//  Description : Self-checking bench for dac_serial_receiver: table of
//                directed frames plus hand-written multi-cycle sequences.
//                A narrow frame counter is used so wrap-around is reachable.
//  Revision    : 1.0 - initial release
// ============================================================================
module tb_dac_serial_receiver;

    localparam int DW = 8;
    localparam int FW = 4;

    logic          clk     = 1'b0;
    logic          rst_n   = 1'b0;
    logic          dac_clk = 1'b0;
    logic          dac_din = 1'b0;
    logic          dac_cs  = 1'b1;
    logic [DW-1:0] data_out;
    logic          data_valid;
    logic          frame_err;
    logic          busy;
    logic [FW-1:0] frame_count;
    logic [7:0]    err_count;

    dac_serial_receiver #(
        .DATA_WIDTH (DW),
        .FCNT_WIDTH (FW)
    ) dut (
        .clk         (clk),
        .rst_n       (rst_n),
        .dac_clk     (dac_clk),
        .dac_din     (dac_din),
        .dac_cs      (dac_cs),
        .data_out    (data_out),
        .data_valid  (data_valid),
        .frame_err   (frame_err),
        .busy        (busy),
        .frame_count (frame_count),
        .err_count   (err_count)
    );

    always #5 clk = ~clk;

    int checks = 0;
    int errors = 0;

    typedef struct {
        logic          kind;   // 1 = data_valid, 0 = frame_err
        logic [DW-1:0] data;
        logic [FW-1:0] fcnt;
        logic [7:0]    ecnt;
    } ev_t;

    ev_t ev_q[$];
    ev_t mon_e;
    int  both_cnt = 0;

    // Pulse log, sampled on the falling edge.
    always @(negedge clk) begin
        if (rst_n) begin
            if (data_valid && frame_err) both_cnt++;
            if (data_valid || frame_err) begin
                mon_e.kind = data_valid;
                mon_e.data = data_out;
                mon_e.fcnt = frame_count;
                mon_e.ecnt = err_count;
                ev_q.push_back(mon_e);
            end
        end
    end

    initial begin
        #2000000;
        $display("FAIL watchdog: simulation did not finish in time");
        $fatal(1);
    end

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s: got %0h, expected %0h", name, act, exp);
        end
    endtask

    task automatic cyc(input int n);
        repeat (n) @(negedge clk);
    endtask

    task automatic clock_bit(input logic b);
        dac_din = b;
        cyc(2);
        dac_clk = 1'b1;
        cyc(3);
        dac_clk = 1'b0;
        cyc(1);
    endtask

    task automatic frame_open(input logic [15:0] v, input int n);
        dac_cs = 1'b0;
        cyc(3);
        for (int i = n - 1; i >= 0; i--) clock_bit(v[i]);
        cyc(1);
    endtask

    task automatic send_frame(input logic [15:0] v, input int n, input int gap);
        frame_open(v, n);
        dac_cs = 1'b1;
        cyc(gap);
    endtask

    typedef struct {
        logic [15:0]   value;
        int            nbits;
        int            gap;
        logic          exp_valid;
        logic [DW-1:0] exp_data;
        logic [FW-1:0] exp_fcnt;
        logic [7:0]    exp_ecnt;
    } vec_t;

    vec_t tbl[10];
    int   base;
    logic [7:0] word;

    initial begin
        // Expected values continue from the hand-written 0xA5 frame
        // (frame_count 1, err_count 0).
        tbl[0] = '{16'h0000,  8, 2, 1'b1, 8'h00, 4'd2, 8'd0};
        tbl[1] = '{16'h00FF,  8, 2, 1'b1, 8'hFF, 4'd3, 8'd0};
        tbl[2] = '{16'h003C,  8, 3, 1'b1, 8'h3C, 4'd4, 8'd0};
        tbl[3] = '{16'h001F,  5, 3, 1'b0, 8'h3C, 4'd4, 8'd1};
        tbl[4] = '{16'h05A5, 11, 3, 1'b0, 8'h3C, 4'd4, 8'd2};
        tbl[5] = '{16'h0000,  0, 3, 1'b0, 8'h3C, 4'd4, 8'd3};
        tbl[6] = '{16'h01FF,  9, 3, 1'b0, 8'h3C, 4'd4, 8'd4};
        tbl[7] = '{16'h0003,  7, 3, 1'b0, 8'h3C, 4'd4, 8'd5};
        tbl[8] = '{16'h0002,  2, 3, 1'b0, 8'h3C, 4'd4, 8'd6};
        tbl[9] = '{16'h0096,  8, 3, 1'b1, 8'h96, 4'd5, 8'd6};

        // Reset state while held in reset
        cyc(3);
        check("rst data_out", 32'(data_out), 32'h0);
        check("rst data_valid", 32'(data_valid), 32'h0);
        check("rst frame_err", 32'(frame_err), 32'h0);
        check("rst busy", 32'(busy), 32'h0);
        check("rst frame_count", 32'(frame_count), 32'h0);
        check("rst err_count", 32'(err_count), 32'h0);
        rst_n = 1'b1;
        cyc(10);
        check("post-rst busy", 32'(busy), 32'h0);

        // 0xA5 with busy and pulse latency checks
        dac_cs = 1'b0;
        cyc(1); check("busy fall e1", 32'(busy), 32'h0);
        cyc(1); check("busy fall e2", 32'(busy), 32'h0);
        cyc(1); check("busy fall e3", 32'(busy), 32'h1);
        word = 8'hA5;
        for (int i = 7; i >= 0; i--) clock_bit(word[i]);
        cyc(1);
        base = ev_q.size();
        dac_cs = 1'b1;
        cyc(1); check("A5 valid e1", 32'(data_valid), 32'h0);
        cyc(1); check("A5 valid e2", 32'(data_valid), 32'h0);
        check("busy rise e2", 32'(busy), 32'h1);
        cyc(1); check("A5 valid e3", 32'(data_valid), 32'h1);
        check("busy rise e3", 32'(busy), 32'h0);
        check("A5 data", 32'(data_out), 32'hA5);
        check("A5 fcnt", 32'(frame_count), 32'h1);
        check("A5 ecnt", 32'(err_count), 32'h0);
        cyc(1); check("A5 valid e4", 32'(data_valid), 32'h0);
        check("A5 pulse count", 32'(ev_q.size() - base), 32'h1);
        cyc(4);

        // Table of frames, checked against the pulse log
        base = ev_q.size();
        for (int i = 0; i < 10; i++) send_frame(tbl[i].value, tbl[i].nbits, tbl[i].gap);
        cyc(10);
        check("table pulse count", 32'(ev_q.size() - base), 32'd10);
        for (int i = 0; i < 10; i++) begin
            if (base + i < ev_q.size()) begin
                check($sformatf("tbl%0d kind", i), 32'(ev_q[base+i].kind), 32'(tbl[i].exp_valid));
                check($sformatf("tbl%0d data", i), 32'(ev_q[base+i].data), 32'(tbl[i].exp_data));
                check($sformatf("tbl%0d fcnt", i), 32'(ev_q[base+i].fcnt), 32'(tbl[i].exp_fcnt));
                check($sformatf("tbl%0d ecnt", i), 32'(ev_q[base+i].ecnt), 32'(tbl[i].exp_ecnt));
            end
        end

        // Reset mid-frame, released while cs is still low
        dac_cs = 1'b0;
        cyc(3);
        for (int i = 0; i < 4; i++) clock_bit(1'b1);
        rst_n = 1'b0;
        #1;
        check("midrst data_out", 32'(data_out), 32'h0);
        check("midrst fcnt", 32'(frame_count), 32'h0);
        check("midrst ecnt", 32'(err_count), 32'h0);
        check("midrst busy", 32'(busy), 32'h0);
        cyc(2);
        rst_n = 1'b1;
        for (int i = 0; i < 4; i++) clock_bit(1'b0);
        cyc(1);
        base = ev_q.size();
        dac_cs = 1'b1;
        cyc(10);
        check("interrupted pulses", 32'(ev_q.size() - base), 32'h0);
        check("interrupted fcnt", 32'(frame_count), 32'h0);
        check("interrupted ecnt", 32'(err_count), 32'h0);
        send_frame(16'h005A, 8, 3);
        cyc(6);
        check("5A pulses", 32'(ev_q.size() - base), 32'h1);
        check("5A data", 32'(data_out), 32'h5A);
        check("5A fcnt", 32'(frame_count), 32'h1);
        check("5A ecnt", 32'(err_count), 32'h0);

        // Clock rise coincident with cs fall (first bit) and cs rise (extra)
        base = ev_q.size();
        dac_din = 1'b1;
        dac_cs  = 1'b0;
        dac_clk = 1'b1;
        cyc(3);
        dac_clk = 1'b0;
        cyc(1);
        for (int i = 0; i < 6; i++) clock_bit(1'b0);
        clock_bit(1'b1);
        cyc(2);
        dac_din = 1'b0;
        dac_cs  = 1'b1;
        dac_clk = 1'b1;
        cyc(3);
        dac_clk = 1'b0;
        cyc(5);
        check("81 pulses", 32'(ev_q.size() - base), 32'h1);
        check("81 data", 32'(data_out), 32'h81);
        check("81 fcnt", 32'(frame_count), 32'h2);
        check("81 ecnt", 32'(err_count), 32'h0);

        // Frame counter wrap (4-bit counter here)
        for (int i = 0; i < 13; i++) send_frame(16'(i + 16), 8, 3);
        cyc(5);
        check("fcnt all-ones", 32'(frame_count), 32'hF);
        send_frame(16'h00C7, 8, 3);
        cyc(5);
        check("fcnt wrap", 32'(frame_count), 32'h0);
        check("wrap data", 32'(data_out), 32'hC7);

        // Error counter saturation with empty frames
        for (int i = 0; i < 255; i++) send_frame(16'h0000, 0, 3);
        cyc(5);
        check("ecnt 255", 32'(err_count), 32'd255);
        for (int i = 0; i < 5; i++) send_frame(16'h0000, 0, 3);
        cyc(5);
        check("ecnt saturated", 32'(err_count), 32'd255);
        check("sat data held", 32'(data_out), 32'hC7);
        check("sat fcnt held", 32'(frame_count), 32'h0);
        check("valid+err overlap", 32'(both_cnt), 32'h0);

        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule
`default_nettype wire
